// File: rtl/sram_access_arbiter.sv
// Shares one asynchronous SRAM port between the CPU MAR/MDR path and the debug loader,
// running a registered SETUP / ACCESS / DONE strobe sequence and returning a one-cycle ack.
module sram_access_arbiter #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 16,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_ack_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_ack_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_dout_o,
    output logic              mem_drive_o,
    input  logic [DATA_W-1:0] mem_din_i,
    output logic              mem_ce_n_o,
    output logic              mem_oe_n_o,
    output logic              mem_we_n_o,
    output logic              mem_ub_n_o,
    output logic              mem_lb_n_o,
    output logic              owner_o
);

    if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_bad_wait
        $error("sram_access_arbiter: WAIT_CYC must be within 1..15");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                owner_q, owner_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                dbg_ack_q, dbg_ack_d;
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic                drive_q, drive_d;
    logic                grant_dbg;

    // Strobes are decoded from the next state so every SRAM pin comes straight off a flop.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        owner_d     = owner_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        grant_dbg   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req_i || dbg_req_i) begin
                    // On a tie the port that did not own the last access wins.
                    grant_dbg = dbg_req_i && (!cpu_req_i || !owner_q);
                    owner_d   = grant_dbg;
                    we_d      = grant_dbg ? dbg_we_i    : cpu_we_i;
                    addr_d    = grant_dbg ? dbg_addr_i  : cpu_addr_i;
                    wdata_d   = grant_dbg ? dbg_wdata_i : cpu_wdata_i;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = 4'(WAIT_CYC - 1);
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (owner_q) dbg_rdata_d = mem_din_i;
                        else         cpu_rdata_d = mem_din_i;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        ce_n_d    = (state_d == IDLE);
        oe_n_d    = !(state_d == ACCESS && !we_d);
        we_n_d    = !(state_d == ACCESS && we_d);
        drive_d   = (state_d != IDLE) && we_d;
        cpu_ack_d = (state_d == DONE) && !owner_d;
        dbg_ack_d = (state_d == DONE) && owner_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            owner_q     <= 1'b1;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            drive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            owner_q     <= owner_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dbg_ack_q   <= dbg_ack_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            drive_q     <= drive_d;
        end
    end

    // Byte lanes are always enabled together with chip enable.
    assign mem_addr_o  = addr_q;
    assign mem_dout_o  = wdata_q;
    assign mem_drive_o = drive_q;
    assign mem_ce_n_o  = ce_n_q;
    assign mem_oe_n_o  = oe_n_q;
    assign mem_we_n_o  = we_n_q;
    assign mem_ub_n_o  = ce_n_q;
    assign mem_lb_n_o  = ce_n_q;
    assign cpu_ack_o   = cpu_ack_q;
    assign dbg_ack_o   = dbg_ack_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign dbg_rdata_o = dbg_rdata_q;
    assign owner_o     = owner_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter: a WAIT_CYC=2 instance with a small SRAM model,
// plus WAIT_CYC=1 and WAIT_CYC=15 instances for latency checks.
module tb_sram_access_arbiter;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    logic        cpuReq = 0, cpuWe = 0, dbgReq = 0, dbgWe = 0;
    logic [19:0] cpuAddr = 0, dbgAddr = 0;
    logic [15:0] cpuWdata = 0, dbgWdata = 0;
    logic        cpuAck, dbgAck, memDrive, ceN, oeN, weN, ubN, lbN, owner;
    logic [15:0] cpuRdata, dbgRdata, memDout, memDin;
    logic [19:0] memAddr;

    logic [15:0] sram [0:255];

    sram_access_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYC(2)) dut (
        .clk_i(clk), .rst_ni(rstN),
        .cpu_req_i(cpuReq), .cpu_we_i(cpuWe), .cpu_addr_i(cpuAddr), .cpu_wdata_i(cpuWdata),
        .cpu_ack_o(cpuAck), .cpu_rdata_o(cpuRdata),
        .dbg_req_i(dbgReq), .dbg_we_i(dbgWe), .dbg_addr_i(dbgAddr), .dbg_wdata_i(dbgWdata),
        .dbg_ack_o(dbgAck), .dbg_rdata_o(dbgRdata),
        .mem_addr_o(memAddr), .mem_dout_o(memDout), .mem_drive_o(memDrive), .mem_din_i(memDin),
        .mem_ce_n_o(ceN), .mem_oe_n_o(oeN), .mem_we_n_o(weN), .mem_ub_n_o(ubN), .mem_lb_n_o(lbN),
        .owner_o(owner)
    );

    // SRAM model: returns data only while output-enabled, writes only when driven.
    assign memDin = (!ceN && !oeN) ? sram[memAddr[7:0]] : 16'hDEAD;
    always @(posedge clk) begin
        if (!ceN && !weN && memDrive) sram[memAddr[7:0]] <= memDout;
    end

    logic        w1Req = 0, w15Req = 0;
    logic        w1Ack, w1DAck, w1Drv, w1Ce, w1Oe, w1We, w1Ub, w1Lb, w1Own;
    logic [15:0] w1Rd, w1DRd, w1Dout;
    logic [19:0] w1Addr;
    logic        w15Ack, w15DAck, w15Drv, w15Ce, w15Oe, w15We, w15Ub, w15Lb, w15Own;
    logic [15:0] w15Rd, w15DRd, w15Dout;
    logic [19:0] w15Addr;

    sram_access_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYC(1)) dutW1 (
        .clk_i(clk), .rst_ni(rstN),
        .cpu_req_i(w1Req), .cpu_we_i(1'b0), .cpu_addr_i(20'h00004), .cpu_wdata_i(16'h0000),
        .cpu_ack_o(w1Ack), .cpu_rdata_o(w1Rd),
        .dbg_req_i(1'b0), .dbg_we_i(1'b0), .dbg_addr_i(20'h0), .dbg_wdata_i(16'h0),
        .dbg_ack_o(w1DAck), .dbg_rdata_o(w1DRd),
        .mem_addr_o(w1Addr), .mem_dout_o(w1Dout), .mem_drive_o(w1Drv), .mem_din_i(16'hC0DE),
        .mem_ce_n_o(w1Ce), .mem_oe_n_o(w1Oe), .mem_we_n_o(w1We), .mem_ub_n_o(w1Ub), .mem_lb_n_o(w1Lb),
        .owner_o(w1Own)
    );

    sram_access_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYC(15)) dutW15 (
        .clk_i(clk), .rst_ni(rstN),
        .cpu_req_i(w15Req), .cpu_we_i(1'b0), .cpu_addr_i(20'h00004), .cpu_wdata_i(16'h0000),
        .cpu_ack_o(w15Ack), .cpu_rdata_o(w15Rd),
        .dbg_req_i(1'b0), .dbg_we_i(1'b0), .dbg_addr_i(20'h0), .dbg_wdata_i(16'h0),
        .dbg_ack_o(w15DAck), .dbg_rdata_o(w15DRd),
        .mem_addr_o(w15Addr), .mem_dout_o(w15Dout), .mem_drive_o(w15Drv), .mem_din_i(16'h5A5A),
        .mem_ce_n_o(w15Ce), .mem_oe_n_o(w15Oe), .mem_we_n_o(w15We), .mem_ub_n_o(w15Ub), .mem_lb_n_o(w15Lb),
        .owner_o(w15Own)
    );

    int assertCount = 0;
    int failCount   = 0;
    int oeLow = 0, weLow = 0, weNoDrv = 0, cpuAckCnt = 0, dbgAckCnt = 0, bothAck = 0;

    // Strobe activity monitor on the main instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (!oeN) oeLow++;
        if (!weN) weLow++;
        if (!weN && !memDrive) weNoDrv++;
        if (cpuAck) cpuAckCnt++;
        if (dbgAck) dbgAckCnt++;
        if (cpuAck && dbgAck) bothAck++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic clearMon();
        @(posedge clk);
        oeLow = 0; weLow = 0; weNoDrv = 0; cpuAckCnt = 0; dbgAckCnt = 0; bothAck = 0;
    endtask

    // One access on the main instance; returns edges from sampling edge to ack, and read data.
    task automatic applyStimulus(input bit isDbg, input bit we, input logic [19:0] addr,
                                 input logic [15:0] wdata, output int lat, output logic [15:0] rdata);
        bit seen;
        @(negedge clk);
        if (isDbg) begin dbgReq = 1; dbgWe = we; dbgAddr = addr; dbgWdata = wdata; end
        else       begin cpuReq = 1; cpuWe = we; cpuAddr = addr; cpuWdata = wdata; end
        lat = 0; seen = 0;
        while (!seen && lat < 40) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (isDbg ? dbgAck : cpuAck) seen = 1;
        end
        rdata = isDbg ? dbgRdata : cpuRdata;
        cpuReq = 0; dbgReq = 0;
        if (!seen) checkOutput("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic doReset();
        @(negedge clk); rstN = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); rstN = 1;
    endtask

    int          lat;
    logic [15:0] rd;
    int          order [4];
    int          ackCyc [4];
    int          acks, cyc;

    initial begin
        for (int i = 0; i < 256; i++) sram[i] = 16'h0000;
        sram[8'h10] = 16'hBEEF;
        sram[8'h01] = 16'h1111;
        sram[8'h02] = 16'h2222;
        sram[8'h03] = 16'h3333;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_strobes", {27'd0, ceN, oeN, weN, ubN, lbN}, 32'h1F);
        checkOutput("reset_drive", {31'd0, memDrive}, 32'd0);
        checkOutput("reset_acks", {30'd0, cpuAck, dbgAck}, 32'd0);
        checkOutput("reset_addr_dout", {memAddr[15:0], memDout}, 32'd0);
        checkOutput("reset_rdata", {cpuRdata, dbgRdata}, 32'd0);
        checkOutput("reset_owner", {31'd0, owner}, 32'd1);
        rstN = 1;

        // CPU read
        clearMon();
        applyStimulus(0, 0, 20'h00010, 16'h0, lat, rd);
        checkOutput("cpu_rd_latency", lat, 4);
        checkOutput("cpu_rd_data", {16'd0, rd}, 32'hBEEF);
        checkOutput("cpu_rd_owner", {31'd0, owner}, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("cpu_rd_oe_cycles", oeLow, 2);
        checkOutput("cpu_rd_we_cycles", weLow, 0);
        checkOutput("cpu_rd_ack_count", cpuAckCnt, 1);
        checkOutput("cpu_rd_dbg_ack", dbgAckCnt, 0);
        checkOutput("idle_strobes", {27'd0, ceN, oeN, weN, ubN, lbN}, 32'h1F);

        // DBG write then read-back
        clearMon();
        applyStimulus(1, 1, 20'h0FFFF, 16'h1234, lat, rd);
        checkOutput("dbg_wr_latency", lat, 4);
        checkOutput("dbg_wr_drive_done", {31'd0, memDrive}, 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("dbg_wr_we_cycles", weLow, 2);
        checkOutput("dbg_wr_we_nodrive", weNoDrv, 0);
        checkOutput("dbg_wr_oe_cycles", oeLow, 0);
        checkOutput("dbg_wr_model", {16'd0, sram[8'hFF]}, 32'h1234);
        checkOutput("dbg_wr_cpu_ack", cpuAckCnt, 0);
        applyStimulus(1, 0, 20'h0FFFF, 16'h0, lat, rd);
        checkOutput("dbg_readback", {16'd0, rd}, 32'h1234);
        checkOutput("cpu_rdata_held", {16'd0, cpuRdata}, 32'hBEEF);

        // Contention after a fresh reset: CPU first, then alternating
        doReset();
        clearMon();
        @(negedge clk);
        cpuReq = 1; cpuWe = 0; cpuAddr = 20'h00010;
        dbgReq = 1; dbgWe = 0; dbgAddr = 20'h0FFFF;
        acks = 0; cyc = 0;
        while (acks < 4 && cyc < 60) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (cpuAck || dbgAck) begin
                order[acks] = dbgAck ? 1 : 0;
                ackCyc[acks] = cyc;
                checkOutput("cont_owner", {31'd0, owner}, {31'd0, dbgAck});
                checkOutput("cont_rdata", {16'd0, dbgAck ? dbgRdata : cpuRdata},
                            dbgAck ? 32'h1234 : 32'hBEEF);
                acks++;
                if (acks == 4) begin cpuReq = 0; dbgReq = 0; end
            end
        end
        cpuReq = 0; dbgReq = 0;
        checkOutput("cont_ack_total", acks, 4);
        for (int i = 0; i < 4; i++) checkOutput("cont_order", order[i], i % 2);
        for (int i = 1; i < 4; i++) checkOutput("cont_spacing", ackCyc[i] - ackCyc[i-1], 5);
        checkOutput("cont_both_ack", bothAck, 0);

        // Reset in the middle of a write
        @(negedge clk);
        cpuReq = 1; cpuWe = 1; cpuAddr = 20'h00020; cpuWdata = 16'hAAAA;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mid_in_access", {30'd0, weN, memDrive}, 32'h1);
        rstN = 0; cpuReq = 0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mid_strobes", {27'd0, ceN, oeN, weN, ubN, lbN}, 32'h1F);
        checkOutput("rst_mid_drive", {31'd0, memDrive}, 32'd0);
        checkOutput("rst_mid_addr", {12'd0, memAddr}, 32'd0);
        rstN = 1;
        clearMon();
        repeat (8) @(negedge clk);
        checkOutput("rst_mid_no_ack", cpuAckCnt + dbgAckCnt, 0);
        checkOutput("rst_mid_idle", {31'd0, ceN}, 32'd1);

        // Back-to-back CPU reads with req held
        @(negedge clk);
        cpuReq = 1; cpuWe = 0; cpuAddr = 20'h00001;
        acks = 0; cyc = 0;
        while (acks < 3 && cyc < 40) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (cpuAck) begin
                ackCyc[acks] = cyc;
                checkOutput("b2b_data", {16'd0, cpuRdata}, 32'h1111 * (acks + 1));
                acks++;
                cpuAddr = 20'(acks + 1);
                if (acks == 3) cpuReq = 0;
            end
        end
        cpuReq = 0;
        checkOutput("b2b_count", acks, 3);
        checkOutput("b2b_first_latency", ackCyc[0], 4);
        checkOutput("b2b_spacing1", ackCyc[1] - ackCyc[0], 5);
        checkOutput("b2b_spacing2", ackCyc[2] - ackCyc[1], 5);

        // WAIT_CYC = 1 and 15 latency
        @(negedge clk);
        w1Req = 1; lat = 0;
        while (lat < 40) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (w1Ack) break;
        end
        w1Req = 0;
        checkOutput("w1_latency", lat, 3);
        checkOutput("w1_rdata", {16'd0, w1Rd}, 32'hC0DE);
        @(negedge clk);
        w15Req = 1; lat = 0;
        while (lat < 40) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (w15Ack) break;
        end
        w15Req = 0;
        checkOutput("w15_latency", lat, 17);
        checkOutput("w15_rdata", {16'd0, w15Rd}, 32'h5A5A);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
